axis_frame_receiver: RTL

- AXI-Stream consumer for the framed result stream produced by the accelerator output path: 6 raw header words, then a payload of ReLU'd Q9.10 samples.
- Strips and latches the header, checks payload length against header and TLAST, and forwards the payload on an AXIS master through a 1-deep register slice.
- Sits on the host/PS-facing side, ahead of S2MM DMA or the loopback checker.
- Handles notification frames, which carry a header only.

---
 rtl/axis_frame_receiver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axis_frame_receiver.sv
// axis_frame_receiver: strips a 6-word header from a framed AXIS stream, checks payload length against header and TLAST, forwards the payload
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_*               framed input stream (6 header words, then payload)
//   m_axis_*               payload output through a 1-deep register slice; tlast generated from the word count
//   hdr_flat               latched header, word k at [16k+15:16k]
//   hdr_valid              one-cycle pulse after header word 5 is accepted
//   frame_done             one-cycle pulse on good frame completion
//   err_flags              sticky {relu_viol, missing_tlast, early_tlast, short_header}
//   frame_count            good frames received (wraps)
//   relu_viol_count        payload words with MSB set (saturating)
// Optional feature macro: AXIS_FRAME_RX_RELU_CHECK_EN enables the ReLU sign check; otherwise relu_viol_count and err_flags[3] are 0.
module axis_frame_receiver #(
    parameter int DATA_WIDTH = 20,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [95:0]           hdr_flat,
    output logic                  hdr_valid,
    output logic                  frame_done,
    output logic [3:0]            err_flags,
    output logic [LEN_WIDTH-1:0]  frame_count,
    output logic [LEN_WIDTH-1:0]  relu_viol_count
);
    typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN, DONE} state_t;
    state_t               state;
    logic [2:0]           hdr_idx;
    logic [LEN_WIDTH-1:0] pay_cnt;
    logic [LEN_WIDTH-1:0] plen;
    logic [2:0]           err;
    logic                 accept;
    logic                 last_word;
    logic                 no_payload;
    // word3 and word0 are already latched when word 5 arrives, so the branch can read them from hdr_flat
    assign plen          = LEN_WIDTH'(hdr_flat[63:48]);
    assign no_payload    = hdr_flat[0] || (plen == '0);
    assign last_word     = (pay_cnt == plen - LEN_WIDTH'(1));
    assign s_axis_tready = (state == PAYLOAD) ? (!m_axis_tvalid || m_axis_tready) : (state != DONE);
    assign accept        = s_axis_tvalid && s_axis_tready;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= HDR;
            hdr_idx       <= '0;
            pay_cnt       <= '0;
            hdr_flat      <= '0;
            err           <= '0;
            hdr_valid     <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            case (state)
                HDR: if (accept) begin
                    hdr_flat[16*hdr_idx +: 16] <= s_axis_tdata[15:0];
                    hdr_idx <= (hdr_idx == 3'd5 || s_axis_tlast) ? 3'd0 : hdr_idx + 3'd1;
                    if (hdr_idx != 3'd5) begin
                        if (s_axis_tlast) err[0] <= 1'b1;
                    end else begin
                        hdr_valid <= 1'b1;
                        pay_cnt   <= '0;
                        if (no_payload) begin
                            if (s_axis_tlast) state <= DONE;
                            else begin
                                err[2] <= 1'b1;
                                state  <= DRAIN;
                            end
                        end else if (s_axis_tlast) err[1] <= 1'b1;
                        else state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (accept) begin
                    // an early TLAST still closes the downstream packet
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= s_axis_tdata;
                    m_axis_tlast  <= last_word || s_axis_tlast;
                    pay_cnt       <= pay_cnt + LEN_WIDTH'(1);
                    if (last_word) begin
                        state <= s_axis_tlast ? DONE : DRAIN;
                        if (!s_axis_tlast) err[2] <= 1'b1;
                    end else if (s_axis_tlast) begin
                        err[1] <= 1'b1;
                        state  <= HDR;
                    end
                end
                DRAIN: if (accept && s_axis_tlast) state <= HDR;
                default: begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + LEN_WIDTH'(1);
                    hdr_idx     <= '0;
                    state       <= HDR;
                end
            endcase
        end
    end
`ifdef AXIS_FRAME_RX_RELU_CHECK_EN
    logic relu_flag;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            relu_flag       <= 1'b0;
            relu_viol_count <= '0;
        end else if (state == PAYLOAD && accept && s_axis_tdata[DATA_WIDTH-1]) begin
            relu_flag <= 1'b1;
            if (!(&relu_viol_count)) relu_viol_count <= relu_viol_count + LEN_WIDTH'(1);
        end
    end
    assign err_flags = {relu_flag, err};
`else
    assign relu_viol_count = '0;
    assign err_flags       = {1'b0, err};
`endif
endmodule
